// File: rtl/kyber512_pkg.sv
// Shared Kyber512 decapsulation constants and the verify FSM state encoding.
package kyber512_pkg;
  localparam int unsigned KYBER_CT_WORDS = 92;
  localparam int unsigned KYBER_WORD_W   = 64;
  localparam int unsigned KYBER_CT_W     = 5888;
  localparam int unsigned KYBER_KEY_W    = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMP,
    ST_SEL,
    ST_DONE
  } verify_state_e;
endpackage

// File: rtl/kyber512_cmov.sv
// Constant-time 256-bit conditional move: y = sel ? b : a, without a data-dependent branch.
module kyber512_cmov
  import kyber512_pkg::*;
(
  input  logic [KYBER_KEY_W-1:0] a,
  input  logic [KYBER_KEY_W-1:0] b,
  input  logic                   sel,
  output logic [KYBER_KEY_W-1:0] y
);
  logic [KYBER_KEY_W-1:0] mask;

  always_comb begin
    mask = {KYBER_KEY_W{sel}};
    y    = a ^ (mask & (a ^ b));
  end
endmodule

// File: rtl/kyber512_decaps_verify.sv
// Kyber512 decapsulation re-encryption check: constant-time ciphertext compare and
// implicit-rejection selection of the pre-key (K' on match, z on mismatch).
module kyber512_decaps_verify
  import kyber512_pkg::*;
#(
  parameter int unsigned CT_WORDS = KYBER_CT_WORDS,
  parameter int unsigned WORD_W   = KYBER_WORD_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [KYBER_CT_W-1:0]  i_Ct,
  input  logic [KYBER_KEY_W-1:0] i_Kr_Hi,
  input  logic [KYBER_KEY_W-1:0] i_z,
  input  logic [WORD_W-1:0]      i_ct_word,
  input  logic                   i_ct_valid,
  output logic                   o_ct_ready,
  output logic [KYBER_KEY_W-1:0] o_pre_K,
  output logic                   o_fail,
  output logic                   verify_done
);
  localparam logic [6:0] LAST_IDX = 7'(CT_WORDS - 1);

  verify_state_e          state_q, state_d;
  logic [6:0]             idx_q, idx_d;
  logic [WORD_W-1:0]      diff_q, diff_d;
  logic [KYBER_CT_W-1:0]  ct_q, ct_d;
  logic [KYBER_KEY_W-1:0] kr_q, kr_d;
  logic [KYBER_KEY_W-1:0] z_q, z_d;
  logic [KYBER_KEY_W-1:0] pre_k_q, pre_k_d;
  logic                   fail_q, fail_d;
  logic                   done_q, done_d;
  logic [WORD_W-1:0]      cur_word;
  logic                   mismatch;
  logic [KYBER_KEY_W-1:0] sel_key;

  assign mismatch = |diff_q;

  kyber512_cmov u_cmov (
    .a   (kr_q),
    .b   (z_q),
    .sel (mismatch),
    .y   (sel_key)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    diff_d     = diff_q;
    ct_d       = ct_q;
    kr_d       = kr_q;
    z_d        = z_q;
    pre_k_d    = pre_k_q;
    fail_d     = fail_q;
    done_d     = 1'b0;
    o_ct_ready = 1'b0;
    cur_word   = ct_q[WORD_W*idx_q +: WORD_W];

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          ct_d    = i_Ct;
          kr_d    = i_Kr_Hi;
          z_d     = i_z;
          idx_d   = '0;
          diff_d  = '0;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        o_ct_ready = 1'b1;
        if (i_ct_valid) begin
          diff_d = diff_q | (i_ct_word ^ cur_word);
          // idx parks on the last word instead of wrapping; the state change ends the compare
          if (idx_q == LAST_IDX) state_d = ST_SEL;
          else                   idx_d   = idx_q + 7'd1;
        end
      end
      ST_SEL: begin
        fail_d  = mismatch;
        pre_k_d = sel_key;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      diff_q  <= '0;
      pre_k_q <= '0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
      pre_k_q <= pre_k_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
    end
  end

  // Latched operands need no reset: they are only consumed after an enable reloads them.
  always_ff @(posedge clk) begin
    ct_q <= ct_d;
    kr_q <= kr_d;
    z_q  <= z_d;
  end

  assign o_pre_K     = pre_k_q;
  assign o_fail      = fail_q;
  assign verify_done = done_q;
endmodule

// File: tb/tb_kyber512_decaps_verify.sv
// Self-checking bench for kyber512_decaps_verify: table-driven and random operations
// checked against a word-list reference model, plus re-enable and mid-stream reset sequences.
module tb_kyber512_decaps_verify;
  localparam int CTW = 92;

  logic          clk = 1'b0;
  logic          reset, enable;
  logic [5887:0] i_Ct;
  logic [255:0]  i_Kr_Hi, i_z;
  logic [63:0]   i_ct_word;
  logic          i_ct_valid;
  logic          o_ct_ready;
  logic [255:0]  o_pre_K;
  logic          o_fail;
  logic          verify_done;

  kyber512_decaps_verify #(.CT_WORDS(92), .WORD_W(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .i_Ct        (i_Ct),
    .i_Kr_Hi     (i_Kr_Hi),
    .i_z         (i_z),
    .i_ct_word   (i_ct_word),
    .i_ct_valid  (i_ct_valid),
    .o_ct_ready  (o_ct_ready),
    .o_pre_K     (o_pre_K),
    .o_fail      (o_fail),
    .verify_done (verify_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0]   ct_words [CTW];
  logic [5887:0] ct_vec;

  localparam logic [255:0] KR_A = 256'hfedcba9876543210_0f1e2d3c4b5a6978_a5a5a5a55a5a5a5a_0123456789abcdef;
  localparam logic [255:0] Z_A  = 256'h123456789abcdef0_123456789abcdef0_123456789abcdef0_123456789abcdeab;

  typedef struct {
    string        name;
    int           vmode;     // 0 valid always, 1 valid on even edges, 2 random
    int           flip_w;    // -1 = stream matches
    int           flip_b;
    int           en_at;     // -1 = no second enable
    logic [255:0] kr;
    logic [255:0] z;
    bit           exp_fail;
    int           exp_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input int vmode, input int flip_w, input int flip_b,
                        input int en_at, input logic [255:0] kr, input logic [255:0] z,
                        input int tab_lat, input int tab_fail);
    logic [63:0]  s [CTW];
    logic [255:0] exp_k;
    bit           exp_fail, v, pulsed;
    int           widx, n, lat, acc_n, rdy_err, exp_lat;
    for (int i = 0; i < CTW; i++) s[i] = ct_words[i];
    if (flip_w >= 0) s[flip_w][flip_b] = ~s[flip_w][flip_b];
    exp_fail = 1'b0;
    for (int i = 0; i < CTW; i++) if (s[i] != ct_words[i]) exp_fail = 1'b1;
    if (tab_fail >= 0) chk({name, "_model_fail"}, 256'(exp_fail), 256'(tab_fail));
    exp_k = exp_fail ? z : kr;

    i_Ct = ct_vec; i_Kr_Hi = kr; i_z = z; i_ct_valid = 1'b0; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    widx = 0; n = 0; lat = 0; acc_n = 0; rdy_err = 0; pulsed = 1'b0;
    while (lat == 0 && n < 400) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = ((n + 1) % 2) == 0;
        default: v = ($urandom % 3) != 0;
      endcase
      i_ct_valid = v;
      i_ct_word  = (v && widx < CTW) ? s[widx] : {$urandom, $urandom};
      if (widx < CTW && o_ct_ready !== 1'b1) rdy_err++;
      if (en_at >= 0 && widx == en_at && !pulsed) begin
        enable = 1'b1; i_Kr_Hi = ~kr; i_z = ~z; pulsed = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      enable = 1'b0;
      if (v && widx < CTW) begin
        widx++;
        if (widx == CTW) acc_n = n;
      end
      if (verify_done === 1'b1) lat = n;
    end
    i_ct_valid = 1'b0;
    exp_lat = (tab_lat > 0) ? tab_lat : acc_n + 2;
    chk({name, "_latency"}, 256'(lat), 256'(exp_lat));
    chk({name, "_ready"}, 256'(rdy_err), 256'(0));
    chk({name, "_fail"}, 256'(o_fail), 256'(exp_fail));
    chk({name, "_preK"}, o_pre_K, exp_k);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, 256'(verify_done), 256'(0));
    chk({name, "_preK_hold"}, o_pre_K, exp_k);
  endtask

  initial begin
    int n_done, n_rdy;
    reset = 1'b1; enable = 1'b0; i_ct_valid = 1'b0; i_ct_word = '0;
    i_Kr_Hi = '0; i_z = '0;
    for (int k = 0; k < CTW; k++) begin
      ct_words[k] = {$urandom, $urandom};
      ct_vec[64*k +: 64] = ct_words[k];
    end
    i_Ct = ct_vec;

    vecs[0] = '{"match",       0, -1,  0, -1, KR_A, Z_A, 1'b0,  94};
    vecs[1] = '{"flip_w91_b0", 0, 91,  0, -1, KR_A, Z_A, 1'b1,  94};
    vecs[2] = '{"flip_w0",     0,  0, 63, -1, KR_A, Z_A, 1'b1,  94};
    vecs[3] = '{"stall_match", 1, -1,  0, -1, KR_A, Z_A, 1'b0, 186};
    vecs[4] = '{"stall_flip",  1, 45, 17, -1, KR_A, Z_A, 1'b1, 186};
    vecs[5] = '{"reenable40",  0, -1,  0, 40, KR_A, Z_A, 1'b0,  94};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 256'(o_ct_ready), 256'(0));
    chk("rst_done",  256'(verify_done), 256'(0));
    chk("rst_fail",  256'(o_fail), 256'(0));
    chk("rst_preK",  o_pre_K, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].name, vecs[i].vmode, vecs[i].flip_w, vecs[i].flip_b, vecs[i].en_at,
             vecs[i].kr, vecs[i].z, vecs[i].exp_lat, int'(vecs[i].exp_fail));

    for (int r = 0; r < 6; r++) begin
      int fw;
      fw = ($urandom % 2) ? int'($urandom_range(0, CTW - 1)) : -1;
      run_op("random", 2, fw, int'($urandom_range(0, 63)), -1,
             {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             0, -1);
    end

    // Reset at word 50 aborts the compare; later words must be ignored.
    i_Ct = ct_vec; i_Kr_Hi = KR_A; i_z = Z_A; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    n_done = 0;
    for (int k = 0; k < 50; k++) begin
      i_ct_valid = 1'b1; i_ct_word = ct_words[k];
      @(posedge clk); #1;
      if (verify_done === 1'b1) n_done++;
    end
    reset = 1'b1; i_ct_word = ct_words[50];
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_ready", 256'(o_ct_ready), 256'(0));
    chk("midrst_fail",  256'(o_fail), 256'(0));
    chk("midrst_preK",  o_pre_K, '0);
    n_rdy = 0;
    for (int k = 51; k < CTW + 20; k++) begin
      i_ct_word = (k < CTW) ? ct_words[k] : {$urandom, $urandom};
      @(posedge clk); #1;
      if (verify_done === 1'b1) n_done++;
      if (o_ct_ready === 1'b1) n_rdy++;
    end
    i_ct_valid = 1'b0;
    chk("midrst_no_done",  256'(n_done), 256'(0));
    chk("midrst_no_ready", 256'(n_rdy), 256'(0));

    reset = 1'b1; enable = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; enable = 1'b0;
    chk("rst_over_enable", 256'(o_ct_ready), 256'(0));

    run_op("post_reset", 0, -1, 0, -1, KR_A, Z_A, 94, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/kyber512_decaps_verify.md
KYBER512_DECAPS_VERIFY -- requirements
Module: kyber512_decaps_verify

Interface
REQ-001 Parameter CT_WORDS, default 92, number of ciphertext words compared (5888/64).
REQ-002 Parameter WORD_W, default 64, width of each streamed ciphertext word.
REQ-003 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port enable, input, 1: one-cycle start pulse; sampled only in IDLE.
REQ-006 Port i_Ct, input, 5888: received ciphertext; word k is bits [64k+63:64k].
REQ-007 Port i_Kr_Hi, input, 256: K' from G(m'||H(pk)).
REQ-008 Port i_z, input, 256: implicit-rejection secret z.
REQ-009 Port i_ct_word, input, WORD_W: re-encrypted ciphertext word, streamed word 0 first.
REQ-010 Port i_ct_valid, input, 1: i_ct_word is valid this cycle.
REQ-011 Port o_ct_ready, output, 1: block accepts a word this cycle.
REQ-012 Port o_pre_K, output, 256: selected pre-key for the KDF (K' or z).
REQ-013 Port o_fail, output, 1: ciphertext mismatch flag.
REQ-014 Port verify_done, output, 1: one-cycle pulse marking o_pre_K/o_fail valid.

Function
REQ-015 The FSM SHALL have the states IDLE, CMP, SEL and DONE, with IDLE as the reset state.
REQ-016 In IDLE with enable=1, the block SHALL register i_Ct, i_Kr_Hi and i_z, clear the diff accumulator and word index, and go to CMP.
REQ-017 In CMP, o_ct_ready SHALL be 1; in all other states it SHALL be 0.
REQ-018 A word SHALL be accepted only when i_ct_valid and o_ct_ready are both 1.
REQ-019 On each accept, the block SHALL OR (i_ct_word XOR ct_reg word[idx]) into a WORD_W-bit diff register and increment idx.
REQ-020 When the word at idx=CT_WORDS-1 is accepted, the block SHALL go to SEL.
REQ-021 The block SHALL consume all CT_WORDS words regardless of mismatches (constant time; no early exit).
REQ-022 In SEL, o_fail SHALL be set to the OR-reduction of diff, and o_pre_K to i_z if fail else i_Kr_Hi.
REQ-023 The selection SHALL use a mask-based constant-time select, not a data-dependent branch.
REQ-024 The block SHALL then go to DONE, assert verify_done for exactly one cycle, and return to IDLE.
REQ-025 With i_ct_valid held high, verify_done SHALL assert 94 cycles after the enable edge, independent of the data.
REQ-026 Cycles with i_ct_valid=0 SHALL stall the index and leave diff unchanged.
REQ-027 enable asserted outside IDLE SHALL be ignored, with no restart and no change of latched inputs.
REQ-028 o_pre_K and o_fail SHALL hold their values after DONE until the next SEL.
REQ-029 The index counter SHALL be 7 bits and SHALL never wrap past CT_WORDS-1.

Reset
REQ-030 reset SHALL return the FSM to IDLE and clear idx, diff, o_pre_K, o_fail, verify_done and o_ct_ready to 0.
REQ-031 Reset SHALL take priority over enable and over a word accept in the same cycle.
REQ-032 Reset mid-comparison SHALL abort the operation with no verify_done pulse; words streamed afterwards SHALL be ignored until the next enable.

Structure
REQ-033 CT_WORDS, WORD_W, the ciphertext width (5888) and the FSM state encoding SHALL live in the shared Kyber512 package.
REQ-034 The constant-time 256-bit conditional move SHALL be a sub-module named kyber512_cmov (inputs a, b, sel; output sel?b:a).

Verification
REQ-035 Stream the re-encryption of i_Ct unchanged (the existing ENC test ciphertext), valid held high -> o_fail=0, o_pre_K=i_Kr_Hi, verify_done at cycle 94.
REQ-036 Same stimulus with bit 0 of word 91 flipped -> o_fail=1, o_pre_K=i_z (e.g. z=256'h1234...ab), verify_done still at cycle 94.
REQ-037 Mismatch only in word 0 versus only in word 91 -> identical done latency (constant time).
REQ-038 Deassert i_ct_valid on every other cycle -> correct result, verify_done at cycle 186.
REQ-039 enable pulsed again at word 40 with different i_Kr_Hi -> ignored; the result uses the first i_Kr_Hi.
REQ-040 reset at word 50, then a new enable with a matching stream -> no spurious done, and a clean o_fail=0 result.
